// File: rtl/cpu_pkg.sv
// Shared definitions for the core: opcodes, fetch FSM states, default widths.
// Imported by fetch_unit and pc_counter.
package cpu_pkg;

  localparam int INSTR_W_DEF = 16;
  localparam int PC_W_DEF    = 8;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_LDI  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_JMP  = 4'b0110;
  localparam logic [3:0] OP_HALT = 4'b0111;
  localparam logic [3:0] OP_BEQZ = 4'b1000;
  localparam logic [3:0] OP_STR  = 4'b1001;

  typedef logic [2:0] fetch_state_t;

  localparam fetch_state_t ST_IDLE   = 3'd0;
  localparam fetch_state_t ST_FETCH  = 3'd1;
  localparam fetch_state_t ST_ISSUE  = 3'd2;
  localparam fetch_state_t ST_EXEC   = 3'd3;
  localparam fetch_state_t ST_HALTED = 3'd4;
  localparam fetch_state_t ST_STEP   = 3'd5;

endpackage

// File: rtl/fetch_unit_pc_counter.sv
// PC register: load has priority over inc; inc wraps modulo 2^PC_W.
// Ports: clk, rst_n, inc, load, load_val -> pc.
module pc_counter
  import cpu_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inc,
  input  logic            load,
  input  logic [PC_W-1:0] load_val,
  output logic [PC_W-1:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + {{(PC_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch/sequencing stage: owns PC, imem handshake, IR; optional SINGLE_STEP_EN
// adds dbg_step and a STEP state. Ports: imem_*, instr/opcode/instr_valid, ex_done/ldpc/target/halt, pc, halted.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int PC_W    = PC_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [3:0]         opcode,
  output logic               instr_valid,
  input  logic               ex_done,
  input  logic               ldpc,
  input  logic [PC_W-1:0]    target,
  input  logic               halt,
`ifdef SINGLE_STEP_EN
  input  logic               dbg_step,
`endif
  output logic [PC_W-1:0]    pc,
  output logic               halted
);

  fetch_state_t state_q;
  logic         retire;
  logic         pc_inc;
  logic         pc_load;

  // ldpc/halt/target only matter in the cycle the instruction retires
  assign retire  = ex_done &&
                   (state_q == ST_ISSUE || state_q == ST_EXEC);
  assign pc_inc  = retire && !halt && !ldpc;
  assign pc_load = retire && !halt && ldpc;

  pc_counter #(
    .PC_W (PC_W)
  ) u_pc (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (pc_inc),
    .load     (pc_load),
    .load_val (target),
    .pc       (pc)
  );

  assign imem_addr = pc;
  assign opcode    = instr[INSTR_W-1 -: 4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      imem_req    <= 1'b0;
      instr       <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      instr_valid <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          state_q  <= ST_FETCH;
          imem_req <= 1'b1;
        end
        ST_FETCH: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
            state_q     <= ST_ISSUE;
          end
        end
        ST_ISSUE, ST_EXEC: begin
          if (ex_done) begin
            if (halt) begin
              state_q <= ST_HALTED;
              halted  <= 1'b1;
            end else begin
`ifdef SINGLE_STEP_EN
              state_q  <= ST_STEP;
`else
              // request rises with the pc update
              state_q  <= ST_FETCH;
              imem_req <= 1'b1;
`endif
            end
          end else begin
            state_q <= ST_EXEC;
          end
        end
`ifdef SINGLE_STEP_EN
        ST_STEP: begin
          if (dbg_step) begin
            state_q  <= ST_FETCH;
            imem_req <= 1'b1;
          end
        end
`endif
        ST_HALTED: begin
          state_q <= ST_HALTED;
        end
        default: begin
          state_q  <= ST_IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: random memory, random latencies,
// reference PC model built from the next-PC rules.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] instr;
  logic [3:0]  opcode;
  logic        instr_valid;
  logic        ex_done;
  logic        ldpc;
  logic [7:0]  target;
  logic        halt;
  logic [7:0]  pc;
  logic        halted;
`ifdef SINGLE_STEP_EN
  logic        dbg_step;
`endif

  logic [15:0] mem [256];
  logic [7:0]  mpc;
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .opcode      (opcode),
    .instr_valid (instr_valid),
    .ex_done     (ex_done),
    .ldpc        (ldpc),
    .target      (target),
    .halt        (halt),
`ifdef SINGLE_STEP_EN
    .dbg_step    (dbg_step),
`endif
    .pc          (pc),
    .halted      (halted)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full instruction: wait for req, hold for lat cycles, ack,
  // check IR, retire after exd extra cycles with given ldpc/target/halt.
  task automatic do_instr(input int lat, input int exd, input bit ld,
                          input logic [7:0] tgt, input bit hlt);
    int n;
    logic [15:0] w;
    n = 0;
    while (!imem_req && n < 20) begin
      step();
      n++;
    end
    n_chk++;
    if (imem_req !== 1'b1)
      $display("FAIL req_timeout req=%b want 1", imem_req);
    else n_pass++;
    n_chk++;
    if (imem_addr !== mpc)
      $display("FAIL req_addr addr=%h want %h", imem_addr, mpc);
    else n_pass++;
    for (int i = 0; i < lat; i++) begin
      ex_done = $urandom_range(0, 1);
      step();
      n_chk++;
      if (imem_req !== 1'b1 || imem_addr !== mpc || instr_valid !== 1'b0)
        $display("FAIL req_hold req=%b addr=%h vld=%b want 1 %h 0",
                 imem_req, imem_addr, instr_valid, mpc);
      else n_pass++;
    end
    ex_done = 1'b0;
    w = mem[mpc];
    imem_ack = 1'b1;
    imem_rdata = w;
    step();
    imem_ack = 1'b0;
    imem_rdata = 16'($urandom);
    n_chk++;
    if (instr_valid !== 1'b1 || instr !== w || opcode !== w[15:12] ||
        imem_req !== 1'b0 || pc !== mpc)
      $display("FAIL issue vld=%b ir=%h op=%h req=%b pc=%h want 1 %h %h 0 %h",
               instr_valid, instr, opcode, imem_req, pc, w, w[15:12], mpc);
    else n_pass++;
    if (exd > 0) begin
      for (int i = 0; i < exd; i++) begin
        ex_done = 1'b0;
        ldpc = 1'($urandom);
        halt = 1'($urandom);
        target = 8'($urandom);
        step();
        n_chk++;
        if (instr_valid !== 1'b0 || instr !== w || pc !== mpc ||
            imem_req !== 1'b0)
          $display("FAIL exec_hold vld=%b ir=%h pc=%h req=%b want 0 %h %h 0",
                   instr_valid, instr, pc, imem_req, w, mpc);
        else n_pass++;
      end
    end
    ex_done = 1'b1;
    ldpc = ld;
    target = tgt;
    halt = hlt;
    step();
    ex_done = 1'b0;
    ldpc = 1'b0;
    halt = 1'b0;
    if (hlt) begin
      n_chk++;
      if (halted !== 1'b1 || pc !== mpc || imem_req !== 1'b0)
        $display("FAIL halt halted=%b pc=%h req=%b want 1 %h 0",
                 halted, pc, imem_req, mpc);
      else n_pass++;
    end else begin
      mpc = ld ? tgt : mpc + 8'd1;
`ifdef SINGLE_STEP_EN
      step();
`endif
      n_chk++;
      if (imem_req !== 1'b1 || imem_addr !== mpc || pc !== mpc ||
          instr_valid !== 1'b0 || halted !== 1'b0)
        $display("FAIL next_pc req=%b addr=%h pc=%h vld=%b hlt=%b want 1 %h %h 0 0",
                 imem_req, imem_addr, pc, instr_valid, halted, mpc, mpc);
      else n_pass++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    mpc = 8'h00;
    n_chk++;
    if (imem_req !== 1'b0 || pc !== 8'h00 || instr !== 16'h0 ||
        instr_valid !== 1'b0 || halted !== 1'b0)
      $display("FAIL reset req=%b pc=%h ir=%h vld=%b hlt=%b want 0 00 0000 0 0",
               imem_req, pc, instr, instr_valid, halted);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    imem_ack = 1'b0;
    imem_rdata = 16'h0;
    ex_done = 1'b0;
    ldpc = 1'b0;
    halt = 1'b0;
    target = 8'h0;
`ifdef SINGLE_STEP_EN
    dbg_step = 1'b1;
`endif
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h0123;
    do_reset();
  endtask

  task automatic test_first_fetch();
    // stray ack while IDLE (req low) must not load IR
    imem_ack = 1'b1;
    imem_rdata = 16'hDEAD;
    step();
    imem_ack = 1'b0;
    n_chk++;
    if (instr_valid !== 1'b0 || instr !== 16'h0 || imem_req !== 1'b1)
      $display("FAIL stray_ack vld=%b ir=%h req=%b want 0 0000 1",
               instr_valid, instr, imem_req);
    else n_pass++;
    do_instr(0, 0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_latency();
    do_instr(5, 0, 1'b0, 8'h00, 1'b0);
    do_instr(3, 4, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_jump_wrap();
    do_instr(1, 0, 1'b1, 8'h40, 1'b0);
    do_instr(0, 2, 1'b1, 8'hFF, 1'b0);
    do_instr(2, 0, 1'b0, 8'h33, 1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 30; k++)
      do_instr($urandom_range(0, 4), $urandom_range(0, 3),
               1'($urandom), 8'($urandom), 1'b0);
  endtask

  task automatic test_reset_mid_fetch();
    do_instr(0, 0, 1'b1, 8'h22, 1'b0);
    step();
    step();
    #3;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (imem_req !== 1'b0 || pc !== 8'h00)
      $display("FAIL mid_reset req=%b pc=%h want 0 00", imem_req, pc);
    else n_pass++;
    mpc = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_chk++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h00)
      $display("FAIL refetch req=%b addr=%h want 1 00", imem_req, imem_addr);
    else n_pass++;
    do_instr(1, 1, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_halt();
    do_instr(0, 0, 1'b1, 8'h10, 1'b0);
    do_instr(2, 1, 1'b1, 8'h55, 1'b1);
    for (int i = 0; i < 20; i++) begin
      imem_ack = 1'($urandom);
      ex_done = 1'($urandom);
      ldpc = 1'($urandom);
      target = 8'($urandom);
      step();
      n_chk++;
      if (imem_req !== 1'b0 || halted !== 1'b1 || pc !== 8'h10 ||
          instr_valid !== 1'b0)
        $display("FAIL halted_idle req=%b hlt=%b pc=%h vld=%b want 0 1 10 0",
                 imem_req, halted, pc, instr_valid);
      else n_pass++;
    end
    imem_ack = 1'b0;
    ex_done = 1'b0;
    ldpc = 1'b0;
  endtask

`ifdef SINGLE_STEP_EN
  task automatic test_single_step();
    do_reset();
    do_instr(0, 0, 1'b1, 8'h03, 1'b0);
    dbg_step = 1'b0;
    while (!(instr_valid === 1'b1) && n_chk < 100000) begin
      imem_ack = imem_req;
      imem_rdata = mem[imem_addr];
      step();
    end
    imem_ack = 1'b0;
    ex_done = 1'b1;
    step();
    ex_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_chk++;
      if (imem_req !== 1'b0 || pc !== 8'h04)
        $display("FAIL step_wait req=%b pc=%h want 0 04", imem_req, pc);
      else n_pass++;
    end
    dbg_step = 1'b1;
    step();
    n_chk++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h04)
      $display("FAIL step_go req=%b addr=%h want 1 04", imem_req, imem_addr);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_first_fetch();
    test_latency();
    test_jump_wrap();
    test_random();
    test_reset_mid_fetch();
    test_halt();
`ifdef SINGLE_STEP_EN
    test_single_step();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch and sequencing stage, sitting directly upstream of the combinational control decoder.
- Owns the PC and handles the request/acknowledge handshake with instruction memory.
- Holds the fetched word in an instruction register (IR) and presents its opcode to the decoder.
- Consumes the decoder's ldpc/halt outputs plus the ALU-produced jump target to choose the next PC; stops permanently on HALT.

Parameters:
- INSTR_W, 16: instruction width; opcode = instr[INSTR_W-1 -: 4].
- PC_W, 8: PC / instruction-memory address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request, held until acknowledged.
- imem_addr  out  PC_W  fetch address (= pc).
- imem_ack  in  1  memory acknowledge; imem_rdata valid this cycle.
- imem_rdata  in  INSTR_W  fetched instruction word.
- instr  out  INSTR_W  IR contents, stable from ISSUE until next IR load.
- opcode  out  4  instr[INSTR_W-1 -: 4], feeds the decoder.
- instr_valid  out  1  one-cycle pulse: new instruction in IR.
- ex_done  in  1  execute/writeback of current instruction complete.
- ldpc  in  1  decoder: load PC from target.
- target  in  PC_W  jump/branch target (ALU result, low PC_W bits).
- halt  in  1  decoder: HALT opcode.
- pc  out  PC_W  current PC.
- halted  out  1  core stopped.

Behaviour:
- Reset (async, rst_n=0): state IDLE; pc=0, instr=0, instr_valid=0, imem_req=0, halted=0. All outputs registered.
- FSM states: IDLE, FETCH, ISSUE, EXEC, HALTED.
- IDLE: unconditionally -> FETCH on the next edge; imem_req rises that edge.
- FETCH:
  - imem_req=1, imem_addr=pc, both held stable until imem_ack.
  - On imem_ack: IR<=imem_rdata, imem_req<=0, instr_valid<=1, -> ISSUE.
  - imem_ack while imem_req=0 is ignored.
- ISSUE: instr_valid=1 for exactly this cycle; ex_done is sampled here, so single-cycle execute is allowed. If ex_done=0 -> EXEC.
- EXEC: waits for ex_done, IR held. ldpc/halt/target are sampled only in the cycle ex_done=1.
- Next-PC rules on ex_done:
  - halt=1 -> HALTED, pc unchanged. halt takes priority over a simultaneous ldpc.
  - else ldpc=1 -> pc<=target, -> FETCH.
  - else pc<=pc+1 modulo 2^PC_W (0xFF wraps to 0x00), -> FETCH.
- FETCH re-entry: imem_req=1 on the edge that updates pc, so address and request appear together.
- HALTED: halted=1, imem_req=0; ex_done/ack ignored; exit only via rst_n.
- Minimum loop: ack at cycle N, ISSUE at N+1 (ex_done=1), req at N+2 → 2 cycles per instruction excluding memory latency.
- Reset mid-handshake: request dropped immediately (async); memory must tolerate an abandoned request.

Optional Feature:
- Macro SINGLE_STEP_EN.
- When defined:
  - Adds input dbg_step (1 bit) and state STEP.
  - After a non-halt ex_done the FSM goes to STEP with the new pc already updated.
  - Stays in STEP until dbg_step=1, then -> FETCH.
  - dbg_step sampled only in STEP.
- When undefined: no port, no state; ex_done goes directly to FETCH as above.

Decomposition:
- Shared package cpu_pkg:
  - Opcode constants: OP_ADD=0000, OP_SUB=0001, OP_LDI=0010, OP_XOR=0011, OP_AND=0100, OP_JMP=0110, OP_HALT=0111, OP_BEQZ=1000, OP_STR=1001.
  - Fetch state enum.
  - Default INSTR_W/PC_W.
- One natural sub-module: pc_counter (PC register; inputs inc, load, load_val; wraps modulo 2^PC_W).

Test Plan:
- Reset release, memory acks one cycle after req with 0x0123 → imem_addr=0x00 with req high; instr=0x0123, opcode=0x0, one-cycle instr_valid; ex_done in ISSUE → next req at addr 0x01, two cycles after ack.
- Memory delays ack 5 cycles → imem_req and imem_addr stay constant throughout; a stray ack before req is ignored.
- ex_done with ldpc=1, target=0x40 → next imem_addr=0x40; with ldpc=0 from pc=0xFF → next addr 0x00.
- ex_done with halt=1 and ldpc=1 together at pc=0x10 → halted=1, pc stays 0x10, no further requests for 20 cycles.
- rst_n asserted mid-FETCH at pc=0x22 → req drops immediately, pc=0; refetch starts from 0x00 after release.
- SINGLE_STEP_EN: ex_done at pc=0x03 → pc=0x04, no req until dbg_step pulses; req follows on the next edge.
